vp_row_fetcher: RTL and testbench
=================================

// Module: vp_row_fetcher
// PURPOSE
//  Per-scanline scheduler for the text/graphics decode stage.
//  On each line_start it converts the scanline index into a text row and a character row.
//  It then issues one memory read per column and forwards each returned charattr word, with
//  char_row, ypos and enabled, to the decode stage.
//  Sits between the video timing generator, the video-memory arbiter port and the decode stage.
// PARAMETERS
//  COLUMNS      80  character cells fetched per scanline (1..255)
//  ROWS         51  text rows per frame
//  CHAR_HEIGHT  20  scanlines per character row (<=32)
//  ADDR_WIDTH   23  word address width of the video-memory port
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  reset          in   1           synchronous, active-low (0 = reset)
//  line_start     in   1           1-cycle pulse: begin fetch for line_y
//  line_y         in   10          scanline index sampled with line_start
//  base_address   in   ADDR_WIDTH  word address of text row 0, column 0; sampled with line_start
//  mem_request    out  1           read request valid
//  mem_address    out  ADDR_WIDTH  read word address
//  mem_ready      in   1           arbiter accepts request this cycle
//  mem_data_valid in   1           in-order read data strobe
//  mem_data       in   32          read data (charattr word)
//  charattr       out  32          charattr word to decode stage
//  char_row       out  5           scanline within character row (0..CHAR_HEIGHT-1)
//  ypos           out  4           line_y[3:0], pattern row for decode stage
//  enabled        out  1           charattr/char_row/ypos valid this cycle
//  busy           out  1           high from accepted line_start until the line completes
//  overrun        out  1           1-cycle pulse: line_start arrived while busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-line aborts the line at once.
//   mem_data_valid is ignored in IDLE, so data from the aborted line is dropped.
//  States: IDLE -> DIVIDE -> FETCH -> DRAIN -> IDLE.
//  IDLE, line_start=1: latch line_y, base_address; rem<=line_y; addr<=base_address; row<=0; ->DIVIDE; busy<=1.
//  DIVIDE: while rem>=CHAR_HEIGHT, each cycle does rem-=CHAR_HEIGHT, addr+=COLUMNS and row+=1.
//   When rem<CHAR_HEIGHT, char_row<=rem[4:0] and the block moves to FETCH.
//   Latency is floor(line_y/CHAR_HEIGHT)+1 cycles.
//   If row reaches ROWS (line_y >= ROWS*CHAR_HEIGHT), the block goes to IDLE and busy<=0.
//   No request is issued and no enabled pulse is produced.
//  FETCH: mem_request=1, mem_address=addr. A request is accepted on a cycle with mem_request&&mem_ready.
//   On acceptance: addr+=1, req_count+=1. When req_count reaches COLUMNS the block moves to DRAIN,
//   with mem_request dropping the cycle after the last acceptance.
//   While mem_ready=0, mem_request and mem_address are held stable.
//  Responses (FETCH or DRAIN): on mem_data_valid, the cycle after has charattr<=mem_data, enabled<=1
//   and resp_count+=1. Otherwise enabled<=0. char_row and ypos hold for the whole line.
//  DRAIN: when resp_count reaches COLUMNS the block goes to IDLE; busy<=0 the same cycle.
//   mem_data_valid beyond COLUMNS responses is ignored.
//  Simultaneous events:
//   - A response may arrive in the same cycle as a request acceptance; both counters update.
//   - line_start while busy: overrun=1 for one cycle. The new request is dropped and the current line completes.
//   - line_start on the same cycle busy falls is treated as busy (overrun).
//  Arithmetic: addr wraps modulo 2^ADDR_WIDTH; the counters are 8-bit.
//   rem is 10-bit and never underflows, because the subtraction only happens when rem>=CHAR_HEIGHT.
//  No enabled pulse occurs outside busy, except the final one in the cycle after busy falls.
// TESTING
//  1. line_y=0, base=0x001000, mem_ready=1, data 2 cycles later:
//     addresses 0x1000..0x104F; 80 enabled pulses; char_row=0; ypos=0.
//  2. line_y=45: DIVIDE takes 3 cycles; first address base+160; char_row=5; ypos=13.
//  3. line_y=1020: busy for 52 cycles; no mem_request; no enabled pulse.
//  4. mem_ready toggled 1,0,1,0: address held while ready=0; exactly 80 accepts, no duplicate or skipped address.
//  5. line_start mid-FETCH: overrun pulses once; the current line completes with 80 words; no new line starts.
//  6. reset=0 mid-FETCH at column 30, then stray mem_data_valid: all outputs 0, enabled stays 0, state IDLE.

Source files
------------

// File: rtl/vp_row_fetcher_if.sv
// Video-memory read port between the row fetcher (master) and the memory arbiter (slave).
// Requests are in-order; read data returns on mem_data_valid in request order.
interface vp_row_fetcher_if #(
  parameter int unsigned ADDR_WIDTH = 23
) ();
  logic                  mem_request;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_ready;
  logic                  mem_data_valid;
  logic [31:0]           mem_data;

  modport master (
    output mem_request,
    output mem_address,
    input  mem_ready,
    input  mem_data_valid,
    input  mem_data
  );

  modport slave (
    input  mem_request,
    input  mem_address,
    output mem_ready,
    output mem_data_valid,
    output mem_data
  );
endinterface

// File: rtl/vp_row_fetcher.sv
// Per-scanline text row fetcher: divides line_y into text row / char row, reads one
// charattr word per column and forwards the returned words to the decode stage.
module vp_row_fetcher #(
  parameter int unsigned COLUMNS     = 80,
  parameter int unsigned ROWS        = 51,
  parameter int unsigned CHAR_HEIGHT = 20,
  parameter int unsigned ADDR_WIDTH  = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_line_start,
  input  logic [9:0]            i_line_y,
  input  logic [ADDR_WIDTH-1:0] i_base_address,
  vp_row_fetcher_if.master      mem,
  output logic [31:0]           o_charattr,
  output logic [4:0]            o_char_row,
  output logic [3:0]            o_ypos,
  output logic                  o_enabled,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int unsigned LINE_W = 10;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CROW_W = 5;
  localparam int unsigned YPOS_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FETCH  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                r_state;
  logic [LINE_W-1:0]     r_rem;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_row;
  logic [CNT_W-1:0]      r_req_count;
  logic [CNT_W-1:0]      r_resp_count;
  logic                  r_mem_request;
  logic [DATA_W-1:0]     r_charattr;
  logic [CROW_W-1:0]     r_char_row;
  logic [YPOS_W-1:0]     r_ypos;
  logic                  r_enabled;
  logic                  r_busy;
  logic                  r_overrun;

  state_t                w_state;
  logic [LINE_W-1:0]     w_rem;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [CNT_W-1:0]      w_row;
  logic [CNT_W-1:0]      w_req_count;
  logic [CNT_W-1:0]      w_resp_count;
  logic                  w_mem_request;
  logic [DATA_W-1:0]     w_charattr;
  logic [CROW_W-1:0]     w_char_row;
  logic [YPOS_W-1:0]     w_ypos;
  logic                  w_enabled;
  logic                  w_busy;
  logic                  w_overrun;
  logic                  w_accept;
  logic                  w_resp_take;

  // Responses are only taken while a line is in flight and never beyond COLUMNS words.
  assign w_accept    = r_mem_request && mem.mem_ready;
  assign w_resp_take = mem.mem_data_valid
                    && ((r_state == S_FETCH) || (r_state == S_DRAIN))
                    && (r_resp_count < CNT_W'(COLUMNS));

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_addr        <= '0;
      r_row         <= '0;
      r_req_count   <= '0;
      r_resp_count  <= '0;
      r_mem_request <= 1'b0;
      r_charattr    <= '0;
      r_char_row    <= '0;
      r_ypos        <= '0;
      r_enabled     <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rem         <= w_rem;
      r_addr        <= w_addr;
      r_row         <= w_row;
      r_req_count   <= w_req_count;
      r_resp_count  <= w_resp_count;
      r_mem_request <= w_mem_request;
      r_charattr    <= w_charattr;
      r_char_row    <= w_char_row;
      r_ypos        <= w_ypos;
      r_enabled     <= w_enabled;
      r_busy        <= w_busy;
      r_overrun     <= w_overrun;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    w_state       = r_state;
    w_rem         = r_rem;
    w_addr        = r_addr;
    w_row         = r_row;
    w_req_count   = r_req_count;
    w_resp_count  = r_resp_count;
    w_mem_request = r_mem_request;
    w_charattr    = r_charattr;
    w_char_row    = r_char_row;
    w_ypos        = r_ypos;
    w_enabled     = 1'b0;
    w_busy        = r_busy;
    // r_busy is still high on the cycle busy falls, so a line_start there is an overrun too.
    w_overrun     = i_line_start && r_busy;

    if (w_resp_take) begin
      w_charattr   = mem.mem_data;
      w_enabled    = 1'b1;
      w_resp_count = r_resp_count + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (i_line_start) begin
          w_state      = S_DIVIDE;
          w_rem        = i_line_y;
          w_addr       = i_base_address;
          w_row        = '0;
          w_req_count  = '0;
          w_resp_count = '0;
          w_ypos       = i_line_y[YPOS_W-1:0];
          w_busy       = 1'b1;
        end
      end
      S_DIVIDE: begin
        // One subtraction per cycle; lines below the last text row are skipped entirely.
        if (r_row >= CNT_W'(ROWS)) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end else if (r_rem >= LINE_W'(CHAR_HEIGHT)) begin
          w_rem  = r_rem - LINE_W'(CHAR_HEIGHT);
          w_addr = r_addr + ADDR_WIDTH'(COLUMNS);
          w_row  = r_row + CNT_W'(1);
        end else begin
          w_char_row    = r_rem[CROW_W-1:0];
          w_state       = S_FETCH;
          w_mem_request = 1'b1;
        end
      end
      S_FETCH: begin
        if (w_accept) begin
          w_addr      = r_addr + ADDR_WIDTH'(1);
          w_req_count = r_req_count + CNT_W'(1);
          if (r_req_count == CNT_W'(COLUMNS - 1)) begin
            w_state       = S_DRAIN;
            w_mem_request = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if ((r_resp_count == CNT_W'(COLUMNS))
            || (w_resp_take && (r_resp_count == CNT_W'(COLUMNS - 1)))) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign mem.mem_request = r_mem_request;
  assign mem.mem_address = r_addr;
  assign o_charattr      = r_charattr;
  assign o_char_row      = r_char_row;
  assign o_ypos          = r_ypos;
  assign o_enabled       = r_enabled;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_vp_row_fetcher.sv
// Directed bench for vp_row_fetcher: a 2-cycle-latency memory model plus a monitor
// that records accepts and forwarded words, checked with immediate assertions.
module tb_vp_row_fetcher;

  localparam int unsigned AW = 23;

  logic          clk;
  logic          reset;
  logic          line_start;
  logic [9:0]    line_y;
  logic [AW-1:0] base_address;
  logic [31:0]   charattr;
  logic [4:0]    char_row;
  logic [3:0]    ypos;
  logic          enabled;
  logic          busy;
  logic          overrun;

  vp_row_fetcher_if #(.ADDR_WIDTH(AW)) mif ();

  vp_row_fetcher #(
    .COLUMNS(80), .ROWS(51), .CHAR_HEIGHT(20), .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_line_start   (line_start),
    .i_line_y       (line_y),
    .i_base_address (base_address),
    .mem            (mif),
    .o_charattr     (charattr),
    .o_char_row     (char_row),
    .o_ypos         (ypos),
    .o_enabled      (enabled),
    .o_busy         (busy),
    .o_overrun      (overrun)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Monitor statistics, cleared between tests.
  logic [AW-1:0] acc_q[$];
  logic [31:0]   en_q[$];
  int            n_req, n_busy, n_ovr, hold_viol, cyc, first_busy, first_req;
  logic          prev_req, prev_acc;
  logic [AW-1:0] prev_addr;
  logic          stray_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model and monitor: sampled 1 time unit after each falling edge.
  initial begin : mon
    logic          pv0, pv1, acc;
    logic [AW-1:0] pa0, pa1;
    pv0 = 1'b0; pv1 = 1'b0; pa0 = '0; pa1 = '0;
    mif.mem_data_valid = 1'b0;
    mif.mem_data       = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      acc = mif.mem_request && mif.mem_ready;
      if (busy) begin
        n_busy++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (mif.mem_request) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
        if (prev_req && !prev_acc && (mif.mem_address != prev_addr)) hold_viol++;
      end else if (prev_req && !prev_acc) begin
        hold_viol++;
      end
      if (acc) acc_q.push_back(mif.mem_address);
      if (enabled) en_q.push_back(charattr);
      if (overrun) n_ovr++;
      prev_req  = mif.mem_request;
      prev_acc  = acc;
      prev_addr = mif.mem_address;
      mif.mem_data_valid = pv1 | stray_v;
      mif.mem_data       = pv1 ? (32'hA500_0000 | 32'(pa1)) : 32'hDEAD_BEEF;
      pv1 = pv0; pa1 = pa0;
      pv0 = acc; pa0 = mif.mem_address;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    acc_q.delete();
    en_q.delete();
    n_req = 0; n_busy = 0; n_ovr = 0; hold_viol = 0;
    first_busy = -1; first_req = -1;
    prev_req = 1'b0; prev_acc = 1'b0; prev_addr = '0;
  endtask

  task automatic start_line(input logic [9:0] y, input logic [AW-1:0] base);
    @(negedge clk);
    line_start   = 1'b1;
    line_y       = y;
    base_address = base;
    @(negedge clk);
    line_start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      #2;
      if (!busy) break;
    end
    chk({tag, "_idle_timeout"}, 64'(k < 1000), 64'd1);
    repeat (4) @(negedge clk);
    #2;
  endtask

  function automatic int addr_err(input logic [AW-1:0] first);
    int e = 0;
    foreach (acc_q[i]) if (acc_q[i] !== AW'(first + AW'(i))) e++;
    return e;
  endfunction

  function automatic int data_err(input logic [AW-1:0] first);
    int e = 0;
    foreach (en_q[i]) if (en_q[i] !== (32'hA500_0000 | 32'(AW'(first + AW'(i))))) e++;
    return e;
  endfunction

  function automatic logic [AW-1:0] first_acc();
    return (acc_q.size() > 0) ? acc_q[0] : '1;
  endfunction

  task automatic check_line(input string tag, input logic [AW-1:0] first);
    chk({tag, "_accepts"},   64'(acc_q.size()), 64'd80);
    chk({tag, "_first_addr"}, 64'(first_acc()), 64'(first));
    chk({tag, "_addr_seq"},  64'(addr_err(first)), 64'd0);
    chk({tag, "_words"},     64'(en_q.size()), 64'd80);
    chk({tag, "_data_seq"},  64'(data_err(first)), 64'd0);
  endtask

  initial begin : stim
    int k;
    reset        = 1'b0;
    line_start   = 1'b0;
    line_y       = '0;
    base_address = '0;
    mif.mem_ready = 1'b1;
    stray_v      = 1'b0;
    cyc          = 0;
    clear_stats();

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_enabled",  64'(enabled), 64'd0);
    chk("rst_request",  64'(mif.mem_request), 64'd0);
    chk("rst_address",  64'(mif.mem_address), 64'd0);
    chk("rst_charattr", 64'(charattr), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: line 0, text row 0
    clear_stats();
    start_line(10'd0, AW'(32'h001000));
    wait_idle("t1");
    check_line("t1", AW'(32'h001000));
    chk("t1_char_row", 64'(char_row), 64'd0);
    chk("t1_ypos",     64'(ypos), 64'd0);
    chk("t1_div_lat",  64'(first_req - first_busy), 64'd1);

    // 2: line 45 -> row 2, char row 5; base near the top so the address wraps
    clear_stats();
    start_line(10'd45, AW'(32'h7FFFF0));
    wait_idle("t2");
    check_line("t2", AW'(32'h000090));
    chk("t2_char_row", 64'(char_row), 64'd5);
    chk("t2_ypos",     64'(ypos), 64'd13);
    chk("t2_div_lat",  64'(first_req - first_busy), 64'd3);

    // 3: line 1020 is past the last text row
    clear_stats();
    start_line(10'd1020, AW'(32'h001000));
    wait_idle("t3");
    chk("t3_busy_cycles", 64'(n_busy), 64'd52);
    chk("t3_requests",    64'(n_req), 64'd0);
    chk("t3_words",       64'(en_q.size()), 64'd0);

    // 4: line 207 -> row 10, char row 7, ready toggling every cycle
    clear_stats();
    start_line(10'd207, AW'(32'h002000));
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      mif.mem_ready = ~mif.mem_ready;
      #2;
      if (!busy) break;
    end
    chk("t4_idle_timeout", 64'(k < 1000), 64'd1);
    mif.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check_line("t4", AW'(32'h002320));
    chk("t4_hold_viol", 64'(hold_viol), 64'd0);
    chk("t4_char_row",  64'(char_row), 64'd7);
    chk("t4_ypos",      64'(ypos), 64'd15);

    // 5: line_start during FETCH is an overrun and is dropped
    clear_stats();
    start_line(10'd21, AW'(32'h004000));
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      #2;
      if (acc_q.size() >= 20) break;
    end
    chk("t5_reach_col20", 64'(k < 500), 64'd1);
    start_line(10'd0, AW'(32'h000000));
    wait_idle("t5");
    check_line("t5", AW'(32'h004050));
    chk("t5_overruns", 64'(n_ovr), 64'd1);
    chk("t5_char_row", 64'(char_row), 64'd1);
    clear_stats();
    repeat (10) @(negedge clk);
    #2;
    chk("t5_no_new_req",  64'(n_req), 64'd0);
    chk("t5_no_new_busy", 64'(n_busy), 64'd0);

    // 6: reset during FETCH, then stray read data
    clear_stats();
    start_line(10'd0, AW'(32'h008000));
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      #2;
      if (acc_q.size() >= 30) break;
    end
    chk("t6_reach_col30", 64'(k < 500), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("t6_rst_busy",     64'(busy), 64'd0);
    chk("t6_rst_request",  64'(mif.mem_request), 64'd0);
    chk("t6_rst_outputs",  64'({charattr, char_row, ypos, enabled, overrun}), 64'd0);
    chk("t6_rst_address",  64'(mif.mem_address), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_stats();
    @(negedge clk);
    stray_v = 1'b1;
    repeat (3) @(negedge clk);
    stray_v = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    chk("t6_stray_words", 64'(en_q.size()), 64'd0);
    chk("t6_stray_busy",  64'(n_busy), 64'd0);
    chk("t6_stray_req",   64'(n_req), 64'd0);
    chk("t6_charattr",    64'(charattr), 64'd0);

    // 7: last scanline of a character row, after the aborted line
    clear_stats();
    start_line(10'd19, AW'(32'h000010));
    wait_idle("t7");
    check_line("t7", AW'(32'h000010));
    chk("t7_char_row", 64'(char_row), 64'd19);
    chk("t7_ypos",     64'(ypos), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
